// File: rtl/arith_test_harness.sv
// Self-calibrating stimulus/check harness for a two-operand WIDTH-bit arithmetic DUT.
// Measures the DUT's pipeline latency, then issues stimulus and checks each result
// against a reference computed from a delayed copy of the operands.
module arith_test_harness #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MAX_LATENCY = 8,
    parameter int unsigned OP          = 0,
    parameter logic [31:0] SEED_A      = 32'hCAFEF00D,
    parameter logic [31:0] SEED_B      = 32'hFEEDC0DE
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [31:0]      i_run_len,
    input  logic [WIDTH-1:0] i_dut_out,
    output logic [WIDTH-1:0] o_drive_a,
    output logic [WIDTH-1:0] o_drive_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cal_fail,
    output logic [3:0]       o_latency,
    output logic [31:0]      o_data_ctr,
    output logic [31:0]      o_event_ctr,
    output logic [WIDTH-1:0] o_err_a,
    output logic [WIDTH-1:0] o_err_b,
    output logic [WIDTH-1:0] o_err_got
);

    // Right-shifting Galois feedback masks for maximal-length sequences, widths 3..32.
    function automatic logic [31:0] lfsr_mask(input int unsigned w);
        case (w)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCal   = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam int unsigned CntW = $clog2(2 * MAX_LATENCY + 1);
    localparam int unsigned SwW  = 2 * WIDTH;

    localparam logic [WIDTH-1:0] LfsrMask = WIDTH'(lfsr_mask(WIDTH));
    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SeedA =
        (SEED_A[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SeedB =
        (SEED_B[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED_B[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CalA   = WIDTH'(3);
    localparam logic [WIDTH-1:0] CalB   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CalExp = (OP == 1) ? WIDTH'(2) : WIDTH'(4);

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] corner(input logic [1:0] idx);
        case (idx)
            2'd0:    return '0;
            2'd1:    return WIDTH'(1);
            2'd2:    return {1'b1, {(WIDTH - 1){1'b0}}};
            default: return '1;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] op_ref(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return (OP == 1) ? (a - b) : (a + b);
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       latency_q, latency_d;
    logic             cal_fail_q, cal_fail_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      issued_q, issued_d;
    logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [SwW-1:0]   sweep_q, sweep_d;
    logic [3:0]       corner_q, corner_d;
    logic [WIDTH-1:0] drive_a_q, drive_a_d, drive_b_q, drive_b_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_ctr_q, data_ctr_d, event_ctr_q, event_ctr_d;
    logic             err_seen_q, err_seen_d;
    logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d, err_got_q, err_got_d;

    logic             dl_v_q [MAX_LATENCY];
    logic [WIDTH-1:0] dl_a_q [MAX_LATENCY];
    logic [WIDTH-1:0] dl_b_q [MAX_LATENCY];

    logic             tap_v;
    logic [WIDTH-1:0] tap_a, tap_b;
    logic             check_valid, mismatch, run_done, issue, start_ok, in_flow;

    assign in_flow     = (state_q == StRun) || (state_q == StDrain);
    assign run_done    = (i_run_len != 32'd0) && (issued_q == i_run_len);
    assign issue       = (state_q == StRun) && enable && !run_done;
    assign start_ok    = i_start && ((state_q == StIdle) || (state_q == StDone));
    assign check_valid = in_flow && tap_v;
    assign mismatch    = check_valid && (op_ref(tap_a, tap_b) != i_dut_out);

    // Select the delay-line entry at the measured latency; latency 0 selects nothing.
    always_comb begin
        tap_v = 1'b0;
        tap_a = '0;
        tap_b = '0;
        for (int i = 0; i < MAX_LATENCY; i++) begin
            if (latency_q == 4'(i + 1)) begin
                tap_v = dl_v_q[i];
                tap_a = dl_a_q[i];
                tap_b = dl_b_q[i];
            end
        end
    end

    // Next-state logic: sequencing, stimulus generation, counters and error capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latency_d   = latency_q;
        cal_fail_d  = cal_fail_q;
        mode_d      = mode_q;
        issued_d    = issued_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        sweep_d     = sweep_q;
        corner_d    = corner_q;
        drive_a_d   = drive_a_q;
        drive_b_d   = drive_b_q;
        valid_d     = 1'b0;
        data_ctr_d  = data_ctr_q;
        event_ctr_d = event_ctr_q;
        err_seen_d  = err_seen_q;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_got_d   = err_got_q;

        case (state_q)
            StCal: begin
                cnt_d     = cnt_q + CntW'(1);
                drive_a_d = '0;
                drive_b_d = '0;
                // One-cycle probe follows MAX_LATENCY cycles of zeros.
                if (cnt_q == CntW'(MAX_LATENCY - 1)) begin
                    drive_a_d = CalA;
                    drive_b_d = CalB;
                end
                if ((cnt_q > CntW'(MAX_LATENCY)) && (i_dut_out == CalExp)) begin
                    state_d   = StRun;
                    latency_d = 4'(cnt_q - CntW'(MAX_LATENCY));
                    mode_d    = (i_mode == 2'd3) ? 2'd0 : i_mode;
                    issued_d  = '0;
                end else if (cnt_q == CntW'(2 * MAX_LATENCY)) begin
                    state_d    = StDone;
                    cal_fail_d = 1'b1;
                    latency_d  = '0;
                end
            end
            StRun: begin
                if (issue) begin
                    valid_d  = 1'b1;
                    issued_d = issued_q + 32'd1;
                    case (mode_q)
                        2'd1: begin
                            drive_a_d = sweep_q[WIDTH-1:0];
                            drive_b_d = sweep_q[SwW-1:WIDTH];
                            sweep_d   = sweep_q + SwW'(1);
                        end
                        2'd2: begin
                            drive_a_d = corner(corner_q[1:0]);
                            drive_b_d = corner(corner_q[3:2]);
                            corner_d  = corner_q + 4'd1;
                        end
                        default: begin
                            drive_a_d = lfsr_a_q;
                            drive_b_d = lfsr_b_q;
                            lfsr_a_d  = lfsr_step(lfsr_a_q);
                            lfsr_b_d  = lfsr_step(lfsr_b_q);
                        end
                    endcase
                end
                if (run_done) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                drive_a_d = '0;
                drive_b_d = '0;
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == CntW'(latency_q - 4'd1)) state_d = StDone;
            end
            StIdle, StDone: begin
                drive_a_d = '0;
                drive_b_d = '0;
            end
            default: state_d = StIdle;
        endcase

        if (!freeze) begin
            if (check_valid && (data_ctr_q != '1)) data_ctr_d = data_ctr_q + 32'd1;
            if (mismatch && (event_ctr_q != '1)) event_ctr_d = event_ctr_q + 32'd1;
        end
        // Capture is independent of freeze so the first failure is never lost.
        if (mismatch && !err_seen_q) begin
            err_seen_d = 1'b1;
            err_a_d    = tap_a;
            err_b_d    = tap_b;
            err_got_d  = i_dut_out;
        end

        if (start_ok) begin
            state_d     = StCal;
            cnt_d       = '0;
            latency_d   = '0;
            cal_fail_d  = 1'b0;
            sweep_d     = '0;
            corner_d    = '0;
            data_ctr_d  = '0;
            event_ctr_d = '0;
            err_seen_d  = 1'b0;
            err_a_d     = '0;
            err_b_d     = '0;
            err_got_d   = '0;
        end
    end

    // Control, stimulus and result state registers.
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            latency_q   <= '0;
            cal_fail_q  <= 1'b0;
            mode_q      <= '0;
            issued_q    <= '0;
            lfsr_a_q    <= SeedA;
            lfsr_b_q    <= SeedB;
            sweep_q     <= '0;
            corner_q    <= '0;
            drive_a_q   <= '0;
            drive_b_q   <= '0;
            valid_q     <= 1'b0;
            data_ctr_q  <= '0;
            event_ctr_q <= '0;
            err_seen_q  <= 1'b0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_got_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            latency_q   <= latency_d;
            cal_fail_q  <= cal_fail_d;
            mode_q      <= mode_d;
            issued_q    <= issued_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            sweep_q     <= sweep_d;
            corner_q    <= corner_d;
            drive_a_q   <= drive_a_d;
            drive_b_q   <= drive_b_d;
            valid_q     <= valid_d;
            data_ctr_q  <= data_ctr_d;
            event_ctr_q <= event_ctr_d;
            err_seen_q  <= err_seen_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_got_q   <= err_got_d;
        end
    end

    // Operand delay line; entry i holds what the DUT saw i+1 cycles ago. Empty outside RUN/DRAIN.
    always_ff @(posedge clk_dut) begin
        if (reset || !in_flow) begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                dl_v_q[i] <= 1'b0;
                dl_a_q[i] <= '0;
                dl_b_q[i] <= '0;
            end
        end else begin
            dl_v_q[0] <= valid_q;
            dl_a_q[0] <= drive_a_q;
            dl_b_q[0] <= drive_b_q;
            for (int i = 1; i < MAX_LATENCY; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_a_q[i] <= dl_a_q[i-1];
                dl_b_q[i] <= dl_b_q[i-1];
            end
        end
    end

    assign o_drive_a   = drive_a_q;
    assign o_drive_b   = drive_b_q;
    assign o_busy      = (state_q == StCal) || (state_q == StRun);
    assign o_done      = (state_q == StDone);
    assign o_cal_fail  = cal_fail_q;
    assign o_latency   = latency_q;
    assign o_data_ctr  = data_ctr_q;
    assign o_event_ctr = event_ctr_q;
    assign o_err_a     = err_a_q;
    assign o_err_b     = err_b_q;
    assign o_err_got   = err_got_q;

endmodule

// File: tb/tb_arith_test_harness.sv
// Bench for arith_test_harness: bench-side DUT models feed the harness; expected end-of-run
// results are queued at start and compared by a monitor when o_done rises.
module tb_arith_test_harness;
    localparam int W  = 16;
    localparam int ML = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, freeze, start0, start1;
    logic [1:0]  mode;
    logic [31:0] run_len;

    logic [W-1:0] dut_out0, drive_a0, drive_b0, err_a0, err_b0, err_got0;
    logic         busy0, done0, cal_fail0;
    logic [3:0]   latency0;
    logic [31:0]  data0, event0;

    logic [W4-1:0] dut_out1, drive_a1, drive_b1, err_a1, err_b1, err_got1;
    logic          busy1, done1, cal_fail1;
    logic [3:0]    latency1;
    logic [31:0]   data1, event1;

    arith_test_harness #(.WIDTH(W), .MAX_LATENCY(ML), .OP(0)) u_dut0 (
        .clk_dut(clk), .reset(reset), .enable(enable), .freeze(freeze), .i_start(start0),
        .i_mode(mode), .i_run_len(run_len), .i_dut_out(dut_out0),
        .o_drive_a(drive_a0), .o_drive_b(drive_b0), .o_busy(busy0), .o_done(done0),
        .o_cal_fail(cal_fail0), .o_latency(latency0), .o_data_ctr(data0),
        .o_event_ctr(event0), .o_err_a(err_a0), .o_err_b(err_b0), .o_err_got(err_got0)
    );

    arith_test_harness #(.WIDTH(W4), .MAX_LATENCY(ML), .OP(0)) u_dut1 (
        .clk_dut(clk), .reset(reset), .enable(enable), .freeze(freeze), .i_start(start1),
        .i_mode(mode), .i_run_len(run_len), .i_dut_out(dut_out1),
        .o_drive_a(drive_a1), .o_drive_b(drive_b1), .o_busy(busy1), .o_done(done1),
        .o_cal_fail(cal_fail1), .o_latency(latency1), .o_data_ctr(data1),
        .o_event_ctr(event1), .o_err_a(err_a1), .o_err_b(err_b1), .o_err_got(err_got1)
    );

    // Adder models: selectable latency, optional stuck-at-1 on bit 0 while running, or tied low.
    int           lat0 = 2;
    logic         tie0 = 1'b0, force0 = 1'b0, toggle = 1'b0;
    logic [W-1:0]  pipe0 [ML];
    logic [W4-1:0] pipe1 [2];

    always @(posedge clk) begin
        pipe0[0] <= drive_a0 + drive_b0;
        for (int k = 1; k < ML; k++) pipe0[k] <= pipe0[k-1];
        pipe1[0] <= drive_a1 + drive_b1;
        pipe1[1] <= pipe1[0];
    end

    always_comb begin
        dut_out0 = pipe0[lat0-1];
        if (force0 && (latency0 != 4'd0)) dut_out0[0] = 1'b1;
        if (tie0) dut_out0 = '0;
    end
    assign dut_out1 = pipe1[1];

    always @(negedge clk) if (toggle) enable = ~enable;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          inst;
        logic [3:0]  lat;
        logic [31:0] data;
        logic [31:0] ev;
        logic        fail;
        logic [15:0] ea, eb, eg;
        int          cycles;
        int          start_cyc;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk(input int inst, input int lat, input int data, input int ev,
                                input int fail, input int ea, input int eb, input int eg,
                                input int cycles);
        exp_t e;
        e.inst = inst; e.lat = 4'(lat); e.data = 32'(data); e.ev = 32'(ev);
        e.fail = fail[0]; e.ea = 16'(ea); e.eb = 16'(eb); e.eg = 16'(eg);
        e.cycles = cycles; e.start_cyc = 0;
        return e;
    endfunction

    function automatic logic [15:0] step16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hD008) : (s >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic mon_check(input int inst);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: inst %0d done with nothing expected", inst);
            return;
        end
        e = sb_q.pop_front();
        chk("sb_inst", 32'(inst), 32'(e.inst));
        if (inst == 0) begin
            chk("latency", 32'(latency0), 32'(e.lat));
            chk("data_ctr", data0, e.data);
            chk("event_ctr", event0, e.ev);
            chk("cal_fail", 32'(cal_fail0), 32'(e.fail));
            chk("err_a", 32'(err_a0), 32'(e.ea));
            chk("err_b", 32'(err_b0), 32'(e.eb));
            chk("err_got", 32'(err_got0), 32'(e.eg));
            chk("busy_at_done", 32'(busy0), 32'd0);
        end else begin
            chk("w4_latency", 32'(latency1), 32'(e.lat));
            chk("w4_data_ctr", data1, e.data);
            chk("w4_event_ctr", event1, e.ev);
            chk("w4_cal_fail", 32'(cal_fail1), 32'(e.fail));
        end
        if (e.cycles != 0) chk("done_cycles", 32'(int'(cyc) - e.start_cyc), 32'(e.cycles));
    endtask

    // Monitor: pops the scoreboard whenever either harness signals completion.
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (done0 && !prev0) mon_check(0);
        if (done1 && !prev1) mon_check(1);
        prev0 = done0;
        prev1 = done1;
    end

    task automatic start_test(input int inst, input logic [1:0] md, input int len,
                              input exp_t e, input bit push);
        @(negedge clk);
        mode    = md;
        run_len = 32'(len);
        e.start_cyc = int'(cyc);
        if (push) sb_q.push_back(e);
        if (inst == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: o_done not seen within 5000 cycles");
            sb_q.delete();
        end
    endtask

    // First operands after entering RUN with enable held high follow the seeded LFSRs.
    task automatic check_lfsr();
        logic [15:0] ma = 16'hF00D;
        logic [15:0] mb = 16'hC0DE;
        for (int i = 0; i < 100 && latency0 == 4'd0; i++) @(negedge clk);
        if (latency0 == 4'd0) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_entry_timeout: RUN not reached, latency 0, required nonzero");
            return;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lfsr_a", 32'(drive_a0), 32'(ma));
            chk("lfsr_b", 32'(drive_b0), 32'(mb));
            ma = step16(ma);
            mb = step16(mb);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_drive_a", 32'(drive_a0), 0);
        chk("rst_drive_b", 32'(drive_b0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_cal_fail", 32'(cal_fail0), 0);
        chk("rst_latency", 32'(latency0), 0);
        chk("rst_data_ctr", data0, 0);
        chk("rst_event_ctr", event0, 0);
        chk("rst_err_a", 32'(err_a0), 0);
        chk("rst_err_b", 32'(err_b0), 0);
        chk("rst_err_got", 32'(err_got0), 0);
        chk("rst_w4_done", 32'(done1), 0);
        chk("rst_w4_data_ctr", data1, 0);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        freeze  = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        mode    = 2'd0;
        run_len = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        enable = 1'b1;

        // 2-stage adder, LFSR stimulus, 1000 results.
        start_test(0, 2'd0, 1000, mk(0, 2, 1000, 0, 0, 0, 0, 0, 0), 1'b1);
        check_lfsr();
        wait_done();

        // Bit 0 stuck high, corner sweep: 8 of 16 sums are even.
        force0 = 1'b1;
        start_test(0, 2'd2, 16, mk(0, 2, 16, 8, 0, 0, 0, 1, 0), 1'b1);
        wait_done();

        // Same with freeze held: nothing counted, first failure still captured.
        freeze = 1'b1;
        start_test(0, 2'd2, 16, mk(0, 2, 0, 0, 0, 0, 0, 1, 0), 1'b1);
        wait_done();
        freeze = 1'b0;
        force0 = 1'b0;

        // Latency 5, enable toggling, stray i_start mid-run must be ignored.
        lat0   = 5;
        toggle = 1'b1;
        start_test(0, 2'd0, 50, mk(0, 5, 50, 0, 0, 0, 0, 0, 0), 1'b1);
        repeat (40) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done();
        toggle = 1'b0;
        enable = 1'b1;

        // No response: calibration fails, DONE after 2*ML+2 cycles.
        lat0 = 2;
        tie0 = 1'b1;
        start_test(0, 2'd0, 100, mk(0, 0, 0, 0, 1, 0, 0, 0, 2 * ML + 2), 1'b1);
        wait_done();
        tie0 = 1'b0;

        // 4-bit instance, exhaustive sweep wraps after 256.
        start_test(1, 2'd1, 300, mk(1, 2, 300, 0, 0, 0, 0, 0, 0), 1'b1);
        wait_done();

        // Reset in the middle of an unlimited run, then a clean rerun.
        start_test(0, 2'd0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        start_test(0, 2'd0, 100, mk(0, 2, 100, 0, 0, 0, 0, 0, 0), 1'b1);
        check_lfsr();
        wait_done();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arith_test_harness.md
# arith_test_harness

Self-calibrating, parametrised successor to the arithmetic testbench top. It drives a two-operand WIDTH-bit DUT and measures the DUT's pipeline latency at run time. It supports selectable stimulus modes and operators, and checks every result against an internally delayed reference. Mismatches and checked results are counted, and the first failure is captured for host readout.

## Interface
- WIDTH, 16: operand/result width, min 3
- MAX_LATENCY, 8: largest DUT latency supported, min 1
- OP, 0: reference operator; 0 = a+b, 1 = a-b, both mod 2^WIDTH
- SEED_A, 32'hCAFEF00D: LFSR A seed, low WIDTH bits used, forced nonzero
- SEED_B, 32'hFEEDC0DE: LFSR B seed, low WIDTH bits used, forced nonzero
- clk_dut  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  issue stimulus this cycle (RUN only)
- freeze  in  1  hold both counters
- i_start  in  1  pulse: begin calibration from IDLE or DONE
- i_mode  in  2  0 LFSR random, 1 exhaustive sweep, 2 corners, 3 reserved (treated as 0)
- i_run_len  in  32  stimuli to issue; 0 = unlimited
- i_dut_out  in  WIDTH  DUT result
- o_drive_a, o_drive_b  out  WIDTH  registered operands to DUT
- o_busy  out  1  state is CAL or RUN
- o_done  out  1  state is DONE
- o_cal_fail  out  1  calibration found no response
- o_latency  out  4  measured latency L (0 until calibrated)
- o_data_ctr  out  32  results checked
- o_event_ctr  out  32  mismatches
- o_err_a, o_err_b, o_err_got  out  WIDTH  operands/result of first mismatch

## Operation
- States: IDLE -> CAL on i_start; CAL -> RUN on a match, CAL -> DONE on timeout; RUN -> DRAIN when issued == i_run_len (nonzero); DRAIN -> DONE after L cycles; DONE -> CAL on i_start. i_start is ignored in CAL, RUN and DRAIN.
- CAL:
  - Drive a=b=0 for MAX_LATENCY cycles (flush).
  - Then drive a=3, b=1 for exactly one cycle P, then zeros again.
  - Expected value E = 4 (OP 0) or 2 (OP 1).
  - For k = 1..MAX_LATENCY, sample i_dut_out at cycle P+k. The first k with i_dut_out == E sets L = k.
  - If no match occurs by k = MAX_LATENCY: set o_cal_fail = 1 and L = 0, then go to DONE.
- Entering CAL clears the counters, the error capture, o_cal_fail and o_latency.
- RUN: each cycle with enable = 1 issues one stimulus and increments the issued count. With enable = 0, operands hold and a bubble (valid = 0) enters the delay line.
- Stimulus modes:
  - Mode 0: two maximal-length Galois LFSRs, advanced on issue.
  - Mode 1: {b,a} is a 2*WIDTH-bit counter starting at 0 and wrapping.
  - Mode 2: a, b cycle through the set {0, 1, 2^(WIDTH-1), 2^WIDTH-1}, a fastest, giving 16 pairs that repeat.
  - Mode is sampled on entry to RUN; changes mid-run are ignored.
- Delay line: depth MAX_LATENCY of {valid,a,b}, shifting every cycle in RUN and DRAIN, tapped at L.
- Check: when the tap is valid, compare the reference op(a,b) mod 2^WIDTH with i_dut_out.
  - o_data_ctr += 1 on every valid check.
  - On mismatch, o_event_ctr += 1, and the first mismatch since CAL loads o_err_*.
- freeze = 1: both counters hold and checks in that cycle are not counted. Error capture still occurs.
- Counters saturate at 32'hFFFFFFFF.
- DRAIN/DONE: operands driven 0, no issue. Counters and error capture hold in DONE.

## Timing
- Reset (any state, mid-run included): state IDLE; every output 0, including o_drive_a/b, o_latency, counters and o_err_*. LFSRs are reloaded with their seeds and the sweep/corner indices are cleared.
- o_drive_* are registered: a stimulus issued in cycle t appears at t+1. Its result is checked L cycles after it appears.
- o_busy/o_done update the cycle after the transition edge.
- o_data_ctr reflects a check one cycle after the compare cycle.
- Same-cycle issue and check are independent. Saturation takes priority over increment; freeze takes priority over both.

## Test plan
- 2-stage registered adder, OP 0, mode 0, i_run_len = 1000, enable high: o_latency = 2, o_data_ctr = 1000, o_event_ctr = 0, o_done = 1.
- Same DUT with bit 0 of its result forced to 1, mode 2, i_run_len = 16: o_event_ctr = 8; o_err_a = 0, o_err_b = 0, o_err_got = 1.
- DUT with latency 5, MAX_LATENCY 8, enable toggling 1/0, i_run_len = 50: o_latency = 5, o_data_ctr = 50, o_event_ctr = 0.
- DUT output tied to 0: o_cal_fail = 1, o_latency = 0, o_done = 1 after 2*MAX_LATENCY+2 cycles; counters stay 0.
- WIDTH = 4, mode 1, i_run_len = 300: the sweep wraps after 256; o_data_ctr = 300, o_event_ctr = 0.
- Reset asserted mid-RUN, then i_start: all outputs read 0 after reset; the rerun reproduces an identical LFSR sequence and counts.
